// File: rtl/nwc_mult_if.sv
// Operand streaming and result handshake between the NWC sequencer (master)
// and the negacyclic multiply engine (slave).
interface nwc_mult_if;
  logic [59:0] data_in0;
  logic [59:0] data_in1;
  logic        write_enable;
  logic        start;
  logic [59:0] data_out;
  logic        output_active;

  modport master (output data_in0, data_in1, write_enable, start,
                  input  data_out, output_active);
  modport slave  (input  data_in0, data_in1, write_enable, start,
                  output data_out, output_active);
endinterface

// File: rtl/nwc_mult_engine.sv
// Negacyclic polynomial multiplier mod (x^N + 1, q) built from P parallel MAC cores.
// Each core owns one output index of a P-wide block and sweeps i over 0..N-1.
module nwc_mult_engine #(
  parameter int MOD_INDEX      = 0,
  parameter int LOG_CORE_COUNT = 3,
  parameter int LOG_N          = 11
) (
  input  logic      clk,
  input  logic      rst,
  nwc_mult_if.slave bus
);
  localparam int P  = 1 << LOG_CORE_COUNT;
  localparam int N  = 1 << LOG_N;
  localparam int BW = LOG_N - LOG_CORE_COUNT;

  localparam logic [29:0] Q = (MOD_INDEX == 1) ? 30'd469762049 :
                              (MOD_INDEX == 2) ? 30'd167772161 :
                              (MOD_INDEX == 3) ? 30'd754974721 : 30'd998244353;

  if (MOD_INDEX < 0 || MOD_INDEX > 3) begin : g_bad_mod
    $error("nwc_mult_engine: MOD_INDEX %0d is not in 0..3", MOD_INDEX);
  end
  if (LOG_CORE_COUNT < 0 || LOG_CORE_COUNT > 4 || LOG_CORE_COUNT >= LOG_N) begin : g_bad_cores
    $error("nwc_mult_engine: LOG_CORE_COUNT %0d is not in 0..4", LOG_CORE_COUNT);
  end

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  logic [1:0]       state;
  logic [LOG_N-1:0] widx;
  logic [LOG_N-1:0] iter;
  logic [LOG_N-1:0] ocnt;
  logic [BW-1:0]    blk;

  logic [29:0] mem_a   [N];
  logic [29:0] mem_b   [N];
  logic [29:0] res_mem [N];

  // Pipeline: stage 0 holds operands, stage 1 holds reduced products, then accumulate.
  logic          v0, v1;
  logic          first0, last0, first1, last1;
  logic [BW-1:0] blk0, blk1;
  logic [P-1:0]  neg0, neg1, neg_now;
  logic [29:0]   a0;
  logic [29:0]   b0   [P];
  logic [29:0]   red1 [P];
  logic [29:0]   acc  [P];

  logic [LOG_N-1:0] k_idx    [P];
  logic [LOG_N-1:0] k_res    [P];
  logic [LOG_N-1:0] b_addr   [P];
  logic [59:0]      prod     [P];
  logic [29:0]      red      [P];
  logic [29:0]      term     [P];
  logic [30:0]      sum      [P];
  logic [29:0]      acc_next [P];

  logic [59:0] data_out_r;
  logic        out_act_r;
  logic        unused_hi;

  assign unused_hi         = ^{bus.data_in0[59:30], bus.data_in1[59:30]};
  assign bus.data_out      = data_out_r;
  assign bus.output_active = out_act_r;

  always_comb begin
    neg_now = '0;
    for (int j = 0; j < P; j++) begin
      k_idx[j]  = (LOG_N'(blk) << LOG_CORE_COUNT) | LOG_N'(j);
      k_res[j]  = (LOG_N'(blk1) << LOG_CORE_COUNT) | LOG_N'(j);
      // (k - i) wraps mod N; the wrapped terms are the negacyclic ones.
      b_addr[j]  = k_idx[j] - iter;
      neg_now[j] = (iter > k_idx[j]);
      prod[j]    = {30'd0, a0} * {30'd0, b0[j]};
      red[j]     = 30'(prod[j] % {30'd0, Q});
      term[j]    = (!neg1[j] || red1[j] == 30'd0) ? red1[j] : Q - red1[j];
      sum[j]     = (first1 ? 31'd0 : {1'b0, acc[j]}) + {1'b0, term[j]};
      acc_next[j] = (sum[j] >= {1'b0, Q}) ? 30'(sum[j] - {1'b0, Q}) : sum[j][29:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      widx       <= '0;
      iter       <= '0;
      ocnt       <= '0;
      blk        <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      out_act_r  <= 1'b0;
      data_out_r <= '0;
    end else begin
      v0        <= (state == S_COMPUTE);
      v1        <= v0;
      out_act_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_COMPUTE;
            widx  <= '0;
            iter  <= '0;
            blk   <= '0;
          end else if (bus.write_enable) begin
            widx <= widx + LOG_N'(1);
          end
        end
        S_COMPUTE: begin
          iter <= iter + LOG_N'(1);
          if (&iter) begin
            blk <= blk + BW'(1);
            if (&blk) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!v0 && !v1) begin
            state <= S_OUTPUT;
            ocnt  <= '0;
          end
        end
        default: begin
          out_act_r  <= 1'b1;
          data_out_r <= {30'd0, res_mem[ocnt]};
          ocnt       <= ocnt + LOG_N'(1);
          if (&ocnt) begin
            state <= S_IDLE;
            widx  <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    a0     <= mem_a[iter];
    neg0   <= neg_now;
    first0 <= (iter == '0);
    last0  <= (&iter);
    blk0   <= blk;
    first1 <= first0;
    last1  <= last0;
    blk1   <= blk0;
    neg1   <= neg0;
    for (int j = 0; j < P; j++) begin
      b0[j]   <= mem_b[b_addr[j]];
      red1[j] <= red[j];
      if (v1) acc[j] <= acc_next[j];
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.write_enable) begin
      mem_a[widx] <= bus.data_in0[29:0];
      mem_b[widx] <= bus.data_in1[29:0];
    end
    if (v1 && last1) begin
      for (int j = 0; j < P; j++) res_mem[k_res[j]] <= acc_next[j];
    end
  end
endmodule

// File: tb/tb_nwc_mult_engine.sv
// Drives several engine configurations with the same jobs and compares every result
// against a direct schoolbook negacyclic product computed in the bench.
module tb_nwc_mult_engine;
  localparam int LOG_N = 6;
  localparam int N     = 1 << LOG_N;
  localparam int NG    = 5;
  localparam int CFG_MOD [NG] = '{0, 1, 2, 3, 0};
  localparam int CFG_LCC [NG] = '{3, 0, 3, 0, 0};
  localparam longint unsigned Q_TAB [4] = '{64'd998244353, 64'd469762049,
                                            64'd167772161, 64'd754974721};
  localparam int NV = 9;

  typedef struct {
    int          pat;
    int          k;
    logic [29:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] raw_a, raw_b;
  logic        we, st, clr;
  logic [29:0] out_word [NG];
  logic        out_act  [NG];
  logic        out_hi   [NG];

  logic [29:0] src_a [N];
  logic [29:0] src_b [N];
  logic [29:0] exp_c [NG][N];
  logic [29:0] res   [NG][N];
  int          cnt       [NG];
  int          runs      [NG];
  int          first_cyc [NG];
  logic        prev_act  [NG];
  logic        hi_bad    [NG];
  int          cyc = 0;
  int          start_cyc;
  int          n_checks = 0;
  int          n_err = 0;
  vec_t        vecs [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    localparam logic [29:0] QG = 30'(Q_TAB[CFG_MOD[g]]);
    nwc_mult_if bus ();
    assign bus.data_in0     = {30'd0, raw_a % QG};
    assign bus.data_in1     = {30'd0, raw_b % QG};
    assign bus.write_enable = we;
    assign bus.start        = st;
    assign out_word[g]      = bus.data_out[29:0];
    assign out_hi[g]        = |bus.data_out[59:30];
    assign out_act[g]       = bus.output_active;
    nwc_mult_engine #(.MOD_INDEX(CFG_MOD[g]), .LOG_CORE_COUNT(CFG_LCC[g]), .LOG_N(LOG_N))
      u_dut (.clk(clk), .rst(rst), .bus(bus));
  end

  always @(negedge clk) begin
    for (int g = 0; g < NG; g++) begin
      if (clr) begin
        cnt[g]       <= 0;
        runs[g]      <= 0;
        first_cyc[g] <= -1;
        prev_act[g]  <= 1'b0;
        hi_bad[g]    <= 1'b0;
      end else begin
        prev_act[g] <= out_act[g];
        if (out_act[g]) begin
          if (!prev_act[g]) runs[g] <= runs[g] + 1;
          if (cnt[g] == 0) first_cyc[g] <= cyc;
          if (cnt[g] < N) res[g][cnt[g]] <= out_word[g];
          if (out_hi[g]) hi_bad[g] <= 1'b1;
          cnt[g] <= cnt[g] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit all_done();
    for (int g = 0; g < NG; g++) if (cnt[g] != N || out_act[g]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit any_act();
    for (int g = 0; g < NG; g++) if (out_act[g]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit all_below(input int lim);
    for (int g = 0; g < NG; g++) if (cnt[g] >= lim) return 1'b0;
    return 1'b1;
  endfunction

  // Schoolbook product: x^(i+j) with i+j >= N folds back as -x^(i+j-N).
  task automatic build_model();
    longint unsigned acc [N];
    longint unsigned q, a, b, p;
    for (int g = 0; g < NG; g++) begin
      q = Q_TAB[CFG_MOD[g]];
      for (int k = 0; k < N; k++) acc[k] = 0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a = src_a[i];
          b = src_b[j];
          p = ((a % q) * (b % q)) % q;
          if (i + j < N) acc[i + j] = (acc[i + j] + p) % q;
          else           acc[i + j - N] = (acc[i + j - N] + q - p) % q;
        end
      end
      for (int k = 0; k < N; k++) exp_c[g][k] = 30'(acc[k]);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      src_a[i] = 30'($urandom());
      src_b[i] = 30'($urandom());
    end
    src_a[N-1] = 30'h3FFF_FFFF;
    src_b[0]   = 30'h3FFF_FFFF;
  endtask

  task automatic set_pattern(input int p);
    for (int i = 0; i < N; i++) begin
      src_a[i] = (p == 2) ? 30'd1 : 30'd0;
      src_b[i] = (p == 2) ? 30'd1 : (p == 0) ? 30'($urandom()) : 30'd0;
    end
    if (p == 0) src_a[0] = 30'd1;
    if (p == 1) begin
      src_a[1]   = 30'd1;
      src_b[N-1] = 30'd1;
    end
  endtask

  task automatic load_and_start();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      raw_a = src_a[i];
      raw_b = src_b[i];
      we    = 1'b1;
      tick();
    end
    we = 1'b0;
    st = 1'b1;
    tick();
    start_cyc = cyc;
    st = 1'b0;
  endtask

  task automatic run_job(input bit inject);
    load_and_start();
    for (int t = 0; t < N * N + 1000; t++) begin
      if (all_done()) break;
      if (inject) begin
        st    = (t == 20);
        we    = (t >= 10 && t < 30) || (any_act() && all_below(N - 4));
        raw_a = 30'($urandom());
        raw_b = 30'($urandom());
      end
      tick();
    end
    st = 1'b0;
    we = 1'b0;
    repeat (8) tick();
  endtask

  task automatic check_job(input string tag);
    int bad;
    int lat;
    int lim;
    for (int g = 0; g < NG; g++) begin
      bad = 0;
      for (int k = N - 1; k >= 0; k--) if (res[g][k] !== exp_c[g][k]) bad = k;
      check($sformatf("%s g%0d c[%0d]", tag, g, bad), 64'(res[g][bad]), 64'(exp_c[g][bad]));
      check($sformatf("%s g%0d words", tag, g), 64'(cnt[g]), 64'(N));
      check($sformatf("%s g%0d bursts", tag, g), 64'(runs[g]), 64'd1);
      check($sformatf("%s g%0d upper bits", tag, g), 64'(hi_bad[g]), 64'd0);
      lat = first_cyc[g] - start_cyc;
      lim = N * N / (1 << CFG_LCC[g]) + 64;
      n_checks++;
      if (first_cyc[g] < 0 || lat > lim) begin
        n_err++;
        $display("FAIL %s g%0d latency: got %0d limit %0d", tag, g, lat, lim);
      end
    end
  endtask

  initial begin
    logic [29:0] qv;
    int bad;
    rst   = 1'b1;
    we    = 1'b0;
    st    = 1'b0;
    clr   = 1'b1;
    raw_a = '0;
    raw_b = '0;
    vecs[0] = '{1, 0,  30'd998244352};
    vecs[1] = '{1, 1,  30'd0};
    vecs[2] = '{1, 62, 30'd0};
    vecs[3] = '{1, 63, 30'd0};
    vecs[4] = '{2, 0,  30'd998244291};
    vecs[5] = '{2, 1,  30'd998244293};
    vecs[6] = '{2, 31, 30'd0};
    vecs[7] = '{2, 32, 30'd2};
    vecs[8] = '{2, 63, 30'd64};
    repeat (3) tick();
    for (int g = 0; g < NG; g++) begin
      check($sformatf("reset g%0d output_active", g), 64'(out_act[g]), 64'd0);
      check($sformatf("reset g%0d data_out", g), 64'(out_word[g]), 64'd0);
    end
    rst = 1'b0;
    clr = 1'b0;
    tick();

    for (int p = 0; p < 3; p++) begin
      set_pattern(p);
      build_model();
      run_job(1'b0);
      check_job($sformatf("pattern%0d", p));
      for (int v = 0; v < NV; v++) begin
        if (vecs[v].pat == p) begin
          check($sformatf("vec p%0d c[%0d] g0", p, vecs[v].k), 64'(res[0][vecs[v].k]), 64'(vecs[v].exp));
          check($sformatf("vec p%0d c[%0d] g4", p, vecs[v].k), 64'(res[4][vecs[v].k]), 64'(vecs[v].exp));
        end
      end
      if (p == 0) begin
        for (int g = 0; g < NG; g++) begin
          qv  = 30'(Q_TAB[CFG_MOD[g]]);
          bad = 0;
          for (int k = N - 1; k >= 0; k--) if (res[g][k] !== src_b[k] % qv) bad = k;
          check($sformatf("impulse g%0d c[%0d]", g, bad), 64'(res[g][bad]), 64'(src_b[bad] % qv));
        end
      end
    end

    for (int r = 0; r < 2; r++) begin
      fill_random();
      build_model();
      run_job(1'b0);
      check_job($sformatf("random%0d", r));
    end

    fill_random();
    build_model();
    run_job(1'b1);
    check_job("ignored inputs");

    fill_random();
    load_and_start();
    for (int t = 0; t < N * N + 1000; t++) begin
      if (cnt[0] >= 5) break;
      tick();
    end
    check("pre-reset g0 active", 64'(out_act[0]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    for (int g = 0; g < NG; g++)
      check($sformatf("async reset g%0d output_active", g), 64'(out_act[g]), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (N * N + 200) tick();
    for (int g = 0; g < NG; g++)
      check($sformatf("after reset g%0d words", g), 64'(cnt[g]), 64'd0);

    fill_random();
    build_model();
    run_job(1'b0);
    check_job("post reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
